pa_pmp_perm_chk: RTL and testbench

Permission-check stage directly downstream of the per-entry PMP address comparators. Takes the per-entry IFU/LSU hit vectors plus each entry's pmpcfg R/W/X/L bits, selects the lowest-numbered hit, applies privilege and lock rules, and returns a registered allow/deny response per port with a valid/stall handshake. A first-fault capture register records the address and cause of the first denied access until software clears it.

---
 rtl/pa_pmp_perm_chk.sv | 143 ++++++++++++++
 tb/tb_pa_pmp_perm_chk.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pa_pmp_perm_chk.sv
// PMP permission check: lowest-index hit selection, privilege/lock rules,
// registered per-port allow/deny responses and a first-fault capture register.
module pa_pmp_perm_chk #(
  parameter int ENTRY_NUM = 8
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst,
  input  logic [ENTRY_NUM-1:0] pmp_ifu_hit,
  input  logic [ENTRY_NUM-1:0] pmp_lsu_hit,
  input  logic [ENTRY_NUM-1:0] pmpcfg_r,
  input  logic [ENTRY_NUM-1:0] pmpcfg_w,
  input  logic [ENTRY_NUM-1:0] pmpcfg_x,
  input  logic [ENTRY_NUM-1:0] pmpcfg_l,
  input  logic                 cp0_mmode,
  input  logic                 ifu_req_vld,
  input  logic [31:0]          ifu_acc_addr,
  output logic                 ifu_req_rdy,
  input  logic                 lsu_req_vld,
  input  logic                 lsu_req_st,
  input  logic [31:0]          lsu_acc_addr,
  output logic                 lsu_req_rdy,
  input  logic                 ifu_rsp_stall,
  input  logic                 lsu_rsp_stall,
  output logic                 ifu_rsp_vld,
  output logic                 ifu_rsp_deny,
  output logic                 lsu_rsp_vld,
  output logic                 lsu_rsp_deny,
  input  logic                 fault_clr,
  output logic                 fault_vld,
  output logic [31:0]          fault_addr,
  output logic [1:0]           fault_cause
);

  localparam logic [ENTRY_NUM-1:0] ONE = ENTRY_NUM'(1);

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

  logic [ENTRY_NUM-1:0] ifu_onehot;
  logic [ENTRY_NUM-1:0] lsu_onehot;
  logic [ENTRY_NUM-1:0] lsu_need;
  logic                 ifu_perm;
  logic                 ifu_lock;
  logic                 lsu_perm;
  logic                 lsu_lock;
  logic                 ifu_deny;
  logic                 lsu_deny;
  logic                 ifu_acc;
  logic                 lsu_acc;
  logic                 ifu_fault;
  logic                 lsu_fault;

  logic                 ifu_rsp_vld_reg;
  logic                 ifu_rsp_deny_reg;
  logic                 lsu_rsp_vld_reg;
  logic                 lsu_rsp_deny_reg;
  state_t               state_reg;
  logic [31:0]          fault_addr_reg;
  logic [1:0]           fault_cause_reg;

  // x & -x isolates the lowest set bit, i.e. the highest-priority hit.
  always_comb begin
    ifu_onehot = pmp_ifu_hit & (~pmp_ifu_hit + ONE);
    lsu_onehot = pmp_lsu_hit & (~pmp_lsu_hit + ONE);
    lsu_need   = lsu_req_st ? pmpcfg_w : pmpcfg_r;
    ifu_perm   = |(ifu_onehot & pmpcfg_x);
    ifu_lock   = |(ifu_onehot & pmpcfg_l);
    lsu_perm   = |(lsu_onehot & lsu_need);
    lsu_lock   = |(lsu_onehot & pmpcfg_l);
    // Unlocked entries never restrict M-mode; with no hit only M-mode passes.
    if (|pmp_ifu_hit) ifu_deny = !((cp0_mmode && !ifu_lock) || ifu_perm);
    else              ifu_deny = !cp0_mmode;
    if (|pmp_lsu_hit) lsu_deny = !((cp0_mmode && !lsu_lock) || lsu_perm);
    else              lsu_deny = !cp0_mmode;
  end

  assign ifu_req_rdy = !ifu_rsp_vld_reg || !ifu_rsp_stall;
  assign lsu_req_rdy = !lsu_rsp_vld_reg || !lsu_rsp_stall;
  assign ifu_acc     = ifu_req_vld && ifu_req_rdy;
  assign lsu_acc     = lsu_req_vld && lsu_req_rdy;
  assign ifu_fault   = ifu_acc && ifu_deny;
  assign lsu_fault   = lsu_acc && lsu_deny;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      ifu_rsp_vld_reg  <= 1'b0;
      ifu_rsp_deny_reg <= 1'b0;
      lsu_rsp_vld_reg  <= 1'b0;
      lsu_rsp_deny_reg <= 1'b0;
    end else begin
      if (ifu_acc) begin
        ifu_rsp_vld_reg  <= 1'b1;
        ifu_rsp_deny_reg <= ifu_deny;
      end else if (ifu_req_rdy) begin
        ifu_rsp_vld_reg  <= 1'b0;
      end
      if (lsu_acc) begin
        lsu_rsp_vld_reg  <= 1'b1;
        lsu_rsp_deny_reg <= lsu_deny;
      end else if (lsu_req_rdy) begin
        lsu_rsp_vld_reg  <= 1'b0;
      end
    end
  end

  // A clear coinciding with a new denial re-arms directly onto the new fault.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_reg       <= IDLE;
      fault_addr_reg  <= 32'd0;
      fault_cause_reg <= 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (lsu_fault || ifu_fault) begin
            state_reg       <= HELD;
            fault_addr_reg  <= lsu_fault ? lsu_acc_addr : ifu_acc_addr;
            fault_cause_reg <= lsu_fault ? (lsu_req_st ? 2'b11 : 2'b10) : 2'b01;
          end
        end
        HELD: begin
          if (fault_clr) begin
            if (lsu_fault || ifu_fault) begin
              fault_addr_reg  <= lsu_fault ? lsu_acc_addr : ifu_acc_addr;
              fault_cause_reg <= lsu_fault ? (lsu_req_st ? 2'b11 : 2'b10) : 2'b01;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ifu_rsp_vld  = ifu_rsp_vld_reg;
  assign ifu_rsp_deny = ifu_rsp_deny_reg;
  assign lsu_rsp_vld  = lsu_rsp_vld_reg;
  assign lsu_rsp_deny = lsu_rsp_deny_reg;
  assign fault_vld    = (state_reg == HELD);
  assign fault_addr   = fault_addr_reg;
  assign fault_cause  = fault_cause_reg;

endmodule

// File: tb/tb_pa_pmp_perm_chk.sv
// Bench for pa_pmp_perm_chk: vector table, directed corner sequences and
// randomized traffic against a rule-level reference model.
module tb_pa_pmp_perm_chk;

  logic        forever_cpuclk = 1'b0;
  logic        cpurst = 1'b1;
  logic [7:0]  pmp_ifu_hit = '0, pmp_lsu_hit = '0;
  logic [7:0]  pmpcfg_r = '0, pmpcfg_w = '0, pmpcfg_x = '0, pmpcfg_l = '0;
  logic        cp0_mmode = 1'b0;
  logic        ifu_req_vld = 1'b0, lsu_req_vld = 1'b0, lsu_req_st = 1'b0;
  logic [31:0] ifu_acc_addr = '0, lsu_acc_addr = '0;
  logic        ifu_rsp_stall = 1'b0, lsu_rsp_stall = 1'b0, fault_clr = 1'b0;
  logic        ifu_req_rdy, lsu_req_rdy;
  logic        ifu_rsp_vld, ifu_rsp_deny, lsu_rsp_vld, lsu_rsp_deny;
  logic        fault_vld;
  logic [31:0] fault_addr;
  logic [1:0]  fault_cause;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit        m_iv, m_id, m_lv, m_ld, m_fv;
  bit [31:0] m_fa;
  bit [1:0]  m_fc;

  always #5 forever_cpuclk = ~forever_cpuclk;

  pa_pmp_perm_chk #(.ENTRY_NUM(8)) dut (
    .forever_cpuclk(forever_cpuclk), .cpurst(cpurst),
    .pmp_ifu_hit(pmp_ifu_hit), .pmp_lsu_hit(pmp_lsu_hit),
    .pmpcfg_r(pmpcfg_r), .pmpcfg_w(pmpcfg_w), .pmpcfg_x(pmpcfg_x), .pmpcfg_l(pmpcfg_l),
    .cp0_mmode(cp0_mmode),
    .ifu_req_vld(ifu_req_vld), .ifu_acc_addr(ifu_acc_addr), .ifu_req_rdy(ifu_req_rdy),
    .lsu_req_vld(lsu_req_vld), .lsu_req_st(lsu_req_st), .lsu_acc_addr(lsu_acc_addr),
    .lsu_req_rdy(lsu_req_rdy),
    .ifu_rsp_stall(ifu_rsp_stall), .lsu_rsp_stall(lsu_rsp_stall),
    .ifu_rsp_vld(ifu_rsp_vld), .ifu_rsp_deny(ifu_rsp_deny),
    .lsu_rsp_vld(lsu_rsp_vld), .lsu_rsp_deny(lsu_rsp_deny),
    .fault_clr(fault_clr), .fault_vld(fault_vld),
    .fault_addr(fault_addr), .fault_cause(fault_cause)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Search entries in index order; the first hit alone decides.
  function automatic bit ref_deny(input logic [7:0] hit, input logic [7:0] perm,
                                  input logic [7:0] lck, input bit mm);
    bit found = 0;
    bit d = !mm;
    for (int i = 0; i < 8; i++) begin
      if (!found && hit[i]) begin
        found = 1;
        if (!mm)         d = !perm[i];
        else if (lck[i]) d = !perm[i];
        else             d = 0;
      end
    end
    return d;
  endfunction

  // One clock: check handshake, advance model, clock, then compare all outputs.
  task automatic tick();
    bit ir, lr, idn, ldn, ifl, lfl;
    #1;
    ir  = !m_iv || !ifu_rsp_stall;
    lr  = !m_lv || !lsu_rsp_stall;
    chk("ifu_req_rdy", ifu_req_rdy, ir);
    chk("lsu_req_rdy", lsu_req_rdy, lr);
    idn = ref_deny(pmp_ifu_hit, pmpcfg_x, pmpcfg_l, cp0_mmode);
    ldn = ref_deny(pmp_lsu_hit, lsu_req_st ? pmpcfg_w : pmpcfg_r, pmpcfg_l, cp0_mmode);
    ifl = ifu_req_vld && ir && idn;
    lfl = lsu_req_vld && lr && ldn;
    if (cpurst) begin
      m_iv = 0; m_id = 0; m_lv = 0; m_ld = 0; m_fv = 0; m_fa = 0; m_fc = 0;
    end else begin
      if (ifu_req_vld && ir) begin m_iv = 1; m_id = idn; end else if (ir) m_iv = 0;
      if (lsu_req_vld && lr) begin m_lv = 1; m_ld = ldn; end else if (lr) m_lv = 0;
      if ((!m_fv || fault_clr) && (ifl || lfl)) begin
        m_fv = 1;
        m_fa = lfl ? lsu_acc_addr : ifu_acc_addr;
        m_fc = lfl ? (lsu_req_st ? 2'b11 : 2'b10) : 2'b01;
      end else if (fault_clr) begin
        m_fv = 0;
      end
    end
    @(posedge forever_cpuclk);
    #1;
    $display("t=%0t ifu vld=%0b deny=%0b | lsu vld=%0b deny=%0b | fault vld=%0b cause=%0d addr=%h",
             $time, ifu_rsp_vld, ifu_rsp_deny, lsu_rsp_vld, lsu_rsp_deny,
             fault_vld, fault_cause, fault_addr);
    chk("ifu_rsp_vld", ifu_rsp_vld, m_iv);
    chk("ifu_rsp_deny", ifu_rsp_deny, m_id);
    chk("lsu_rsp_vld", lsu_rsp_vld, m_lv);
    chk("lsu_rsp_deny", lsu_rsp_deny, m_ld);
    chk("fault_vld", fault_vld, m_fv);
    chk("fault_addr", fault_addr, m_fa);
    chk("fault_cause", fault_cause, m_fc);
  endtask

  task automatic idle_inputs();
    ifu_req_vld = 0; lsu_req_vld = 0; ifu_rsp_stall = 0; lsu_rsp_stall = 0;
    fault_clr = 0; cpurst = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    cpurst = 1;
    tick();
    cpurst = 0;
  endtask

  typedef struct {
    logic [7:0] ihit, lhit, r, w, x, l;
    logic       mm, st, exp_id, exp_ld;
  } vec_t;

  vec_t tv[8];

  initial begin
    // ihit lhit r w x l mm st | ifu_deny lsu_deny
    tv[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[1] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[2] = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[3] = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1};
    tv[4] = '{8'h20, 8'h24, 8'h04, 8'h20, 8'h20, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[5] = '{8'h30, 8'h24, 8'h04, 8'h20, 8'h20, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[6] = '{8'h80, 8'h80, 8'hFF, 8'h7F, 8'h80, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[7] = '{8'h06, 8'h06, 8'h04, 8'hFC, 8'hFC, 8'hFC, 1'b0, 1'b1, 1'b1, 1'b1};

    do_reset();
    do_reset();

    // Vector table, one request per port per row, no stall.
    for (int i = 0; i < 8; i++) begin
      pmp_ifu_hit = tv[i].ihit; pmp_lsu_hit = tv[i].lhit;
      pmpcfg_r = tv[i].r; pmpcfg_w = tv[i].w; pmpcfg_x = tv[i].x; pmpcfg_l = tv[i].l;
      cp0_mmode = tv[i].mm; lsu_req_st = tv[i].st;
      ifu_acc_addr = 32'h1000 + i; lsu_acc_addr = 32'h2000 + i;
      ifu_req_vld = 1; lsu_req_vld = 1;
      tick();
      chk($sformatf("tv%0d_ifu_deny", i), ifu_rsp_deny, tv[i].exp_id);
      chk($sformatf("tv%0d_lsu_deny", i), lsu_rsp_deny, tv[i].exp_ld);
    end
    idle_inputs();
    tick();

    // Entry 2 beats entry 5 on a U-mode store.
    do_reset();
    pmp_lsu_hit = 8'h24; pmpcfg_r = 8'h04; pmpcfg_w = 8'h20; pmpcfg_x = 0; pmpcfg_l = 0;
    cp0_mmode = 0; lsu_req_st = 1; lsu_acc_addr = 32'h1234_5678; lsu_req_vld = 1;
    tick();
    chk("seq1_lsu_deny", lsu_rsp_deny, 1);
    chk("seq1_cause", fault_cause, 2'b11);
    chk("seq1_addr", fault_addr, 32'h1234_5678);

    // IFU with no hit: M-mode allowed, U-mode faults.
    do_reset();
    pmp_ifu_hit = 0; cp0_mmode = 1; ifu_acc_addr = 32'h8000_0000; ifu_req_vld = 1;
    tick();
    chk("seq2_mmode_deny", ifu_rsp_deny, 0);
    cp0_mmode = 0;
    tick();
    chk("seq2_umode_deny", ifu_rsp_deny, 1);
    chk("seq2_cause", fault_cause, 2'b01);
    chk("seq2_addr", fault_addr, 32'h8000_0000);

    // Stall holds the LSU response; later inputs must not disturb it.
    do_reset();
    pmp_lsu_hit = 8'h01; pmpcfg_w = 0; pmpcfg_r = 0; pmpcfg_l = 0; cp0_mmode = 0;
    lsu_req_st = 1; lsu_req_vld = 1; lsu_acc_addr = 32'hA0;
    tick();
    lsu_rsp_stall = 1; pmpcfg_w = 8'hFF; cp0_mmode = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("seq3_stall_rdy", lsu_req_rdy, 0);
      chk("seq3_stall_deny", lsu_rsp_deny, 1);
    end
    lsu_rsp_stall = 0;
    tick();
    chk("seq3_resume_deny", lsu_rsp_deny, 0);
    pmpcfg_w = 0; cp0_mmode = 0;
    tick();
    chk("seq3_b2b_vld", lsu_rsp_vld, 1);
    chk("seq3_b2b_deny", lsu_rsp_deny, 1);

    // Simultaneous denials: LSU wins capture; clear plus IFU denial re-captures.
    do_reset();
    pmp_ifu_hit = 0; pmp_lsu_hit = 0; cp0_mmode = 0; lsu_req_st = 0;
    ifu_acc_addr = 32'h11; lsu_acc_addr = 32'h22; ifu_req_vld = 1; lsu_req_vld = 1;
    tick();
    chk("seq4_cause", fault_cause, 2'b10);
    chk("seq4_addr", fault_addr, 32'h22);
    lsu_req_vld = 0; ifu_acc_addr = 32'h33; fault_clr = 1;
    tick();
    chk("seq4_clr_vld", fault_vld, 1);
    chk("seq4_clr_cause", fault_cause, 2'b01);
    chk("seq4_clr_addr", fault_addr, 32'h33);

    // Reset while a fault is held and both responses are valid.
    fault_clr = 0; lsu_req_vld = 1;
    tick();
    cpurst = 1;
    tick();
    chk("seq5_ifu_vld", ifu_rsp_vld, 0);
    chk("seq5_lsu_vld", lsu_rsp_vld, 0);
    chk("seq5_fault_vld", fault_vld, 0);
    chk("seq5_fault_addr", fault_addr, 0);
    idle_inputs();
    tick();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      pmp_ifu_hit = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      pmp_lsu_hit = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      pmpcfg_r = 8'($urandom); pmpcfg_w = 8'($urandom);
      pmpcfg_x = 8'($urandom); pmpcfg_l = 8'($urandom);
      cp0_mmode = 1'($urandom); lsu_req_st = 1'($urandom);
      ifu_req_vld = 1'($urandom); lsu_req_vld = 1'($urandom);
      ifu_acc_addr = $urandom; lsu_acc_addr = $urandom;
      ifu_rsp_stall = ($urandom_range(0, 9) < 3);
      lsu_rsp_stall = ($urandom_range(0, 9) < 3);
      fault_clr = ($urandom_range(0, 9) == 0);
      cpurst = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
